// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage with integrated IF/ID output register, variable-latency req/ack memory port,
// freeze hold buffer and branch redirect. Optional stall counter port enabled by `define IF_STALL_CNT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction,
`ifdef IF_STALL_CNT_EN
    output logic        valid,
    output logic [31:0] stall_cycles
`else
    output logic        valid
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [31:0] stale_addr;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    assign pc_inc = pc + PC_STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_FETCH: begin
                // A redirect with the request still open must wait out the stale response.
                if (branch_taken) begin
                    state_nx = imem_ack ? ST_FETCH : ST_DISCARD;
                end else if (imem_ack && freeze) begin
                    state_nx = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                if (imem_ack) begin
                    state_nx = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (branch_taken || !freeze) begin
                    state_nx = ST_FETCH;
                end
            end
            default: state_nx = ST_FETCH;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            ST_FETCH:   imem_req = rst;
            ST_DISCARD: begin
                imem_req  = rst;
                imem_addr = stale_addr;
            end
            default:    imem_req = 1'b0;
        endcase
    end

    // PC, hold buffer and IF/ID output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            stale_addr  <= 32'd0;
            hold_pc     <= 32'd0;
            hold_instr  <= 32'd0;
            PC_out      <= 32'd0;
            Instruction <= 32'd0;
            valid       <= 1'b0;
        end else if (branch_taken) begin
            pc          <= branch_addr;
            Instruction <= 32'd0;
            valid       <= 1'b0;
            hold_pc     <= 32'd0;
            hold_instr  <= 32'd0;
            if (state == ST_FETCH && !imem_ack) begin
                stale_addr <= pc;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        pc <= pc_inc;
                        if (freeze) begin
                            hold_pc    <= pc_inc;
                            hold_instr <= imem_rdata;
                        end else begin
                            PC_out      <= pc_inc;
                            Instruction <= imem_rdata;
                            valid       <= 1'b1;
                        end
                    end else if (!freeze) begin
                        valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!freeze) begin
                        PC_out      <= hold_pc;
                        Instruction <= hold_instr;
                        valid       <= 1'b1;
                    end
                end
                ST_DISCARD: valid <= 1'b0;
                default:    valid <= 1'b0;
            endcase
        end
    end

`ifdef IF_STALL_CNT_EN
    // Counts memory wait cycles plus frozen cycles, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
        end else if (((imem_req && !imem_ack) || state == ST_HOLD) && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized freeze/branch/latency
// traffic compared every cycle against a transaction-level reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] STEP   = 32'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC_out;
    logic [31:0] Instruction;
    logic        valid;
`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC(RST_PC),
        .PC_STEP (STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PC_out      (PC_out),
        .Instruction (Instruction),
`ifdef IF_STALL_CNT_EN
        .valid       (valid),
        .stall_cycles(stall_cycles)
`else
        .valid       (valid)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: fetch pointer, pending-stale flag, queue of buffered responses, ID-visible output.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        hq[$];
    logic [31:0] m_pc, m_stale, m_pc_out, m_ins, m_stall;
    bit          m_disc, m_valid;

    // Memory responder state
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_wait;
    int          lat_min, lat_max;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h5A5A_3C3C;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        #1;
        check_eq("rst_valid", valid, 32'd0);
        check_eq("rst_instr", Instruction, 32'd0);
        check_eq("rst_req", imem_req, 32'd0);
        check_eq("rst_pcout", PC_out, 32'd0);
`ifdef IF_STALL_CNT_EN
        check_eq("rst_stall", stall_cycles, 32'd0);
`endif
        m_pc = RST_PC; m_stale = 32'd0; m_disc = 0; hq.delete();
        m_pc_out = 32'd0; m_ins = 32'd0; m_valid = 0; m_stall = 32'd0;
        mem_busy = 0; mem_wait = 0; mem_addr = 32'd0;
        freeze = 0; branch_taken = 0; branch_addr = 32'd0; imem_ack = 0; imem_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    // One clock: compare DUT against model, drive inputs, advance model, move to next cycle.
    task automatic step(input bit frz, input bit br, input logic [31:0] baddr);
        bit          ack, hold;
        logic [31:0] rd;
        ent_t        e;
        hold = (hq.size() != 0);
        check_eq("req", imem_req, {31'd0, !hold});
        if (!hold) check_eq("addr", imem_addr, m_disc ? m_stale : m_pc);
        check_eq("valid", valid, {31'd0, m_valid});
        check_eq("pc_out", PC_out, m_pc_out);
        check_eq("instr", Instruction, m_ins);
`ifdef IF_STALL_CNT_EN
        check_eq("stall", stall_cycles, m_stall);
`endif
        ack = 0;
        rd  = $urandom;
        if (imem_req) begin
            if (mem_busy) begin
                check_eq("addr_stable", imem_addr, mem_addr);
            end else begin
                mem_busy = 1;
                mem_addr = imem_addr;
                mem_wait = $urandom_range(lat_max, lat_min);
            end
            if (mem_wait == 0) begin
                ack = 1;
                rd  = mem_word(mem_addr);
                mem_busy = 0;
            end else begin
                mem_wait--;
            end
        end
        freeze = frz; branch_taken = br; branch_addr = baddr;
        imem_ack = ack; imem_rdata = rd;

        if (hold || !ack) m_stall = (m_stall == 32'hFFFF_FFFF) ? m_stall : m_stall + 32'd1;
        if (br) begin
            if (hold) begin
                m_disc = 0;
            end else begin
                if (!m_disc && !ack) m_stale = m_pc;
                m_disc = !ack;
            end
            m_pc = baddr; m_ins = 32'd0; m_valid = 0; hq.delete();
        end else if (hold) begin
            if (!frz) begin
                e = hq.pop_front();
                m_pc_out = e.pc; m_ins = e.ins; m_valid = 1;
            end
        end else if (m_disc) begin
            if (ack) m_disc = 0;
            m_valid = 0;
        end else if (ack) begin
            e.pc = m_pc + STEP; e.ins = rd;
            m_pc = m_pc + STEP;
            if (frz) hq.push_back(e);
            else begin m_pc_out = e.pc; m_ins = e.ins; m_valid = 1; end
        end else if (!frz) begin
            m_valid = 0;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [31:0] a, input string tag);
        int n = 0;
        while (imem_addr !== a && n < 40) begin
            step(0, 0, 32'd0);
            n++;
        end
        check_eq(tag, imem_addr, a);
    endtask

    initial begin
        int vcnt, n;
        logic [31:0] ba;
        rst = 1'b1;
        freeze = 0; branch_taken = 0; branch_addr = 0; imem_ack = 0; imem_rdata = 0;
        lat_min = 0; lat_max = 0;
        #2;

        // Back-to-back fetch with ack tied high
        reset_dut();
        check_eq("first_addr", imem_addr, RST_PC);
        repeat (3) step(0, 0, 32'd0);
        check_eq("seq_addr", imem_addr, 32'd12);
        check_eq("seq_pcout", PC_out, 32'd12);
        check_eq("seq_instr", Instruction, mem_word(32'd8));
        check_eq("seq_valid", valid, 32'd1);

        // Three wait cycles per request: one valid pulse per four cycles
        reset_dut();
        lat_min = 3; lat_max = 3;
        vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 32'd0);
            if (valid === 1'b1) vcnt++;
        end
        check_eq("lat3_pulses", vcnt, 32'd4);

        // Freeze while the response for pc=8 arrives
        reset_dut();
        lat_min = 0; lat_max = 0;
        step(0, 0, 32'd0);
        step(0, 0, 32'd0);
        repeat (4) step(1, 0, 32'd0);
        check_eq("frz_pc_held", PC_out, 32'd8);
        check_eq("frz_req_off", imem_req, 32'd0);
        step(0, 0, 32'd0);
        check_eq("frz_pc_rel", PC_out, 32'd12);
        check_eq("frz_instr_rel", Instruction, mem_word(32'd8));
        check_eq("frz_next_addr", imem_addr, 32'd12);

        // Redirect while a request is pending
        reset_dut();
        lat_min = 3; lat_max = 3;
        step(0, 1, 32'h10);
        wait_addr(32'h10, "reach_0x10");
        step(0, 1, 32'h100);
        check_eq("br_valid0", valid, 32'd0);
        check_eq("br_stale_addr", imem_addr, 32'h10);
        check_eq("br_stale_req", imem_req, 32'd1);
        wait_addr(32'h100, "reach_0x100");
        n = 0;
        while (valid !== 1'b1 && n < 40) begin
            step(0, 0, 32'd0);
            n++;
        end
        check_eq("br_valid1", valid, 32'd1);
        check_eq("br_pcout", PC_out, 32'h104);
        check_eq("br_instr", Instruction, mem_word(32'h100));

        // Branch together with freeze while holding a buffered response
        reset_dut();
        lat_min = 0; lat_max = 0;
        step(0, 0, 32'd0);
        step(1, 0, 32'd0);
        step(1, 1, 32'h200);
        check_eq("hb_valid", valid, 32'd0);
        check_eq("hb_instr", Instruction, 32'd0);
        check_eq("hb_req", imem_req, 32'd1);
        check_eq("hb_addr", imem_addr, 32'h200);
        step(0, 0, 32'd0);
        check_eq("hb_pcout", PC_out, 32'h204);

        // PC wrap-around
        reset_dut();
        step(0, 1, 32'hFFFF_FFF8);
        step(0, 0, 32'd0);
        step(0, 0, 32'd0);
        check_eq("wrap_addr", imem_addr, 32'd0);
        check_eq("wrap_pcout", PC_out, 32'd0);
        check_eq("wrap_instr", Instruction, mem_word(32'hFFFF_FFFC));

        // Reset in the middle of a wait at pc=0x20
        reset_dut();
        step(0, 1, 32'h1C);
        step(0, 0, 32'd0);
        check_eq("mid_valid_pre", valid, 32'd1);
        lat_min = 3; lat_max = 3;
        step(0, 0, 32'd0);
        #2;
        reset_dut();
        check_eq("mid_addr_post", imem_addr, RST_PC);
        check_eq("mid_req_post", imem_req, 32'd1);

        // Randomized traffic
        for (int p = 0; p < 3; p++) begin
            reset_dut();
            lat_min = 0;
            lat_max = (p == 0) ? 0 : ((p == 1) ? 2 : 4);
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 3) == 0) ba = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
                else ba = $urandom & 32'h0000_FFFC;
                step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 6, ba);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
